// File: rtl/trap_queue_if.sv
// Trap queue handshake bundle: trap requests in, pending vector and issue/ack out.
// Latency: pure wiring, no storage.
// Backpressure: none here; the req/ack pair carries the flow control.
// Optional overflow reporting is built only when TRAP_QUEUE_OVF_EN is defined.
interface trap_queue_if #(
    parameter int NUM_TRAPS = 6,
    parameter int TT_W      = 3
);
    logic [NUM_TRAPS-1:0] trap_set;
    logic                 trap_en;
    logic                 flush;
    logic                 ack;
    logic [TT_W-1:0]      ack_tt;
    logic [NUM_TRAPS-1:0] tq_pending;
    logic                 trap_req;
    logic [TT_W-1:0]      trap_tt;
    logic                 error_mode;
    logic                 ack_err;
`ifdef TRAP_QUEUE_OVF_EN
    logic                 ovf;
    logic [7:0]           ovf_cnt;
`endif

    // Pipeline / control-unit side
    modport master (
        output trap_set, trap_en, flush, ack, ack_tt,
        input  tq_pending, trap_req, trap_tt, error_mode, ack_err
`ifdef TRAP_QUEUE_OVF_EN
        , input ovf, ovf_cnt
`endif
    );

    // Trap queue side
    modport slave (
        input  trap_set, trap_en, flush, ack, ack_tt,
        output tq_pending, trap_req, trap_tt, error_mode, ack_err
`ifdef TRAP_QUEUE_OVF_EN
        , output ovf, ovf_cnt
`endif
    );
endinterface

// File: rtl/trap_queue.sv
// Pending-trap register plus issue sequencer presenting the highest-priority trap (bit 0 first).
// Latency: trap_set -> tq_pending 1 cycle, -> trap_req 2 cycles; ack -> clear/req drop 1 cycle.
// Backpressure: a presented trap is held (tt stable) until acked with a matching tt; new traps keep accumulating.
// Optional: TRAP_QUEUE_OVF_EN adds sticky ovf and a saturating 8-bit ovf_cnt for re-set of pending bits.
module trap_queue #(
    parameter int NUM_TRAPS = 6,
    parameter int TT_W      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    trap_queue_if.slave tq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t               state_q;
    logic [NUM_TRAPS-1:0] pending_q;
    logic [NUM_TRAPS-1:0] pending_d;
    logic [NUM_TRAPS-1:0] clr_mask;
    logic                 trap_req_q;
    logic [TT_W-1:0]      trap_tt_q;
    logic                 error_mode_q;
    logic                 ack_err_q;
    logic                 flush_eff;
    logic                 ack_match;

    // Lowest set index wins, matching the downstream tt encoder.
    function automatic logic [TT_W-1:0] prio_enc(input logic [NUM_TRAPS-1:0] v);
        logic [TT_W-1:0] r;
        r = '0;
        for (int i = NUM_TRAPS - 1; i >= 0; i--) begin
            if (v[i]) r = TT_W'(i);
        end
        return r;
    endfunction

    // Flush is not an escape from ERROR: only reset leaves it, so flush is masked there.
    assign flush_eff = tq.flush && (state_q != ERROR);
    // An out-of-range ack_tt can never equal trap_tt, so it falls out as a mismatch.
    assign ack_match = (state_q == REQ) && tq.ack && !flush_eff && (tq.ack_tt == trap_tt_q);

    // Decode the honoured ack type to a one-hot clear mask and form the next pending vector.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_TRAPS; i++) begin
            clr_mask[i] = ack_match && (tq.ack_tt == TT_W'(i));
        end
        // Set after clear: a bit re-raised in the ack cycle stays pending.
        if (flush_eff) pending_d = '0;
        else           pending_d = (pending_q & ~clr_mask) | tq.trap_set;
    end

    // Pending trap register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    // Issue FSM with registered req/tt/error/ack_err outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            trap_req_q   <= 1'b0;
            trap_tt_q    <= '0;
            error_mode_q <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            ack_err_q <= 1'b0;
            if (flush_eff) begin
                state_q    <= IDLE;
                trap_req_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // tt is taken from the registered vector, so a trap is never
                        // presented before it is visible on tq_pending.
                        if (tq.trap_en && (|pending_q)) begin
                            state_q    <= REQ;
                            trap_req_q <= 1'b1;
                            trap_tt_q  <= prio_enc(pending_q);
                        end else if (!tq.trap_en && (|tq.trap_set)) begin
                            state_q      <= ERROR;
                            error_mode_q <= 1'b1;
                        end
                    end
                    REQ: begin
                        // Late higher-priority traps only land in pending; tt is frozen here.
                        if (tq.ack) begin
                            if (ack_match) begin
                                state_q    <= IDLE;
                                trap_req_q <= 1'b0;
                            end else begin
                                ack_err_q <= 1'b1;
                            end
                        end
                    end
                    ERROR: begin
                        error_mode_q <= 1'b1;
                        trap_req_q   <= 1'b0;
                    end
                    default: begin
                        state_q    <= IDLE;
                        trap_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tq.tq_pending = pending_q;
    assign tq.trap_req   = trap_req_q;
    assign tq.trap_tt    = trap_tt_q;
    assign tq.error_mode = error_mode_q;
    assign tq.ack_err    = ack_err_q;

`ifdef TRAP_QUEUE_OVF_EN
    logic       ovf_q;
    logic [7:0] ovf_cnt_q;
    logic       ovf_hit;

    // A set landing on a bit that is pending and not being cleared this cycle is lost.
    assign ovf_hit = !flush_eff && (|(tq.trap_set & pending_q & ~clr_mask));

    // Sticky overflow flag and saturating overflow counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else if (flush_eff) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else if (ovf_hit) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign tq.ovf     = ovf_q;
    assign tq.ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_trap_queue.sv
// Directed bench for trap_queue: priority, latency, tt stability, ack mismatch, flush, error mode, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Overflow checks are compiled in only with TRAP_QUEUE_OVF_EN.
module tb_trap_queue;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    trap_queue_if #(.NUM_TRAPS(6), .TT_W(3)) ifc ();

    trap_queue #(.NUM_TRAPS(6), .TT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tq    (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        ifc.trap_set = '0;
        ifc.trap_en  = 1'b0;
        ifc.flush    = 1'b0;
        ifc.ack      = 1'b0;
        ifc.ack_tt   = '0;
        step();
        step();
        chk("rst_pending", 32'(ifc.tq_pending), 32'h0);
        chk("rst_req",     32'(ifc.trap_req),   32'h0);
        chk("rst_tt",      32'(ifc.trap_tt),    32'h0);
        chk("rst_errmode", 32'(ifc.error_mode), 32'h0);
        chk("rst_ackerr",  32'(ifc.ack_err),    32'h0);
        rst_n = 1'b1;

        // Priority and latency
        ifc.trap_en  = 1'b1;
        ifc.trap_set = 6'b010100;
        step();
        ifc.trap_set = '0;
        chk("lat_pending_n1", 32'(ifc.tq_pending), 32'h14);
        chk("lat_req_n1",     32'(ifc.trap_req),   32'h0);
        step();
        chk("lat_req_n2", 32'(ifc.trap_req), 32'h1);
        chk("lat_tt_n2",  32'(ifc.trap_tt),  32'h2);
        ifc.ack = 1'b1; ifc.ack_tt = 3'd2;
        step();
        ifc.ack = 1'b0;
        chk("ack2_pending", 32'(ifc.tq_pending), 32'h10);
        chk("ack2_idle",    32'(ifc.trap_req),   32'h0);
        step();
        chk("req4_req", 32'(ifc.trap_req), 32'h1);
        chk("req4_tt",  32'(ifc.trap_tt),  32'h4);

        // Higher-priority arrival does not disturb the presented tt
        ifc.trap_set = 6'b000001;
        step();
        ifc.trap_set = '0;
        chk("stab_tt_a",   32'(ifc.trap_tt),    32'h4);
        chk("stab_pending", 32'(ifc.tq_pending), 32'h11);
        step();
        chk("stab_tt_b",  32'(ifc.trap_tt),  32'h4);
        chk("stab_req_b", 32'(ifc.trap_req), 32'h1);

        // Mismatched ack
        ifc.ack = 1'b1; ifc.ack_tt = 3'd3;
        step();
        ifc.ack = 1'b0;
        chk("mis_ackerr",  32'(ifc.ack_err),    32'h1);
        chk("mis_req",     32'(ifc.trap_req),   32'h1);
        chk("mis_pending", 32'(ifc.tq_pending), 32'h11);
        step();
        chk("mis_ackerr_drop", 32'(ifc.ack_err), 32'h0);

        // Ack tt=4 with simultaneous re-set of bit 4
        ifc.ack = 1'b1; ifc.ack_tt = 3'd4; ifc.trap_set = 6'b010000;
        step();
        ifc.ack = 1'b0; ifc.trap_set = '0;
        chk("sim_pending", 32'(ifc.tq_pending), 32'h11);
        chk("sim_idle",    32'(ifc.trap_req),   32'h0);
        chk("sim_ackerr",  32'(ifc.ack_err),    32'h0);
        step();
        chk("next_req0_req", 32'(ifc.trap_req), 32'h1);
        chk("next_req0_tt",  32'(ifc.trap_tt),  32'h0);
        ifc.ack = 1'b1; ifc.ack_tt = 3'd0;
        step();
        ifc.ack = 1'b0;
        chk("ack0_pending", 32'(ifc.tq_pending), 32'h10);
        chk("ack0_idle",    32'(ifc.trap_req),   32'h0);
        step();
        chk("rereq4_req", 32'(ifc.trap_req), 32'h1);
        chk("rereq4_tt",  32'(ifc.trap_tt),  32'h4);
        ifc.ack = 1'b1; ifc.ack_tt = 3'd4;
        step();
        ifc.ack = 1'b0;
        chk("drain_pending", 32'(ifc.tq_pending), 32'h0);
        step();
        chk("drain_idle", 32'(ifc.trap_req), 32'h0);

        // Ack while idle is ignored
        ifc.ack = 1'b1; ifc.ack_tt = 3'd0;
        step();
        ifc.ack = 1'b0;
        chk("idle_ack_noerr", 32'(ifc.ack_err),  32'h0);
        chk("idle_ack_req",   32'(ifc.trap_req), 32'h0);

        // Out-of-range ack_tt counts as a mismatch
        ifc.trap_set = 6'b001000;
        step();
        ifc.trap_set = '0;
        step();
        chk("req3_req", 32'(ifc.trap_req), 32'h1);
        chk("req3_tt",  32'(ifc.trap_tt),  32'h3);
        ifc.ack = 1'b1; ifc.ack_tt = 3'd7;
        step();
        ifc.ack = 1'b0;
        chk("oor_ackerr",  32'(ifc.ack_err),    32'h1);
        chk("oor_pending", 32'(ifc.tq_pending), 32'h08);
        chk("oor_req",     32'(ifc.trap_req),   32'h1);

        // Flush in REQ, with a discarded set in the same cycle
        ifc.flush = 1'b1; ifc.trap_set = 6'b000100;
        step();
        ifc.flush = 1'b0; ifc.trap_set = '0;
        chk("flush_pending", 32'(ifc.tq_pending), 32'h0);
        chk("flush_req",     32'(ifc.trap_req),   32'h0);
        step();
        chk("flush_stay_req",     32'(ifc.trap_req),   32'h0);
        chk("flush_stay_pending", 32'(ifc.tq_pending), 32'h0);

`ifdef TRAP_QUEUE_OVF_EN
        chk("ovf_start", 32'(ifc.ovf), 32'h0);
        ifc.trap_set = 6'b000010;
        repeat (3) step();
        ifc.trap_set = '0;
        chk("ovf_flag",  32'(ifc.ovf),     32'h1);
        chk("ovf_cnt2",  32'(ifc.ovf_cnt), 32'd2);
        ifc.trap_set = 6'b000010;
        repeat (300) step();
        ifc.trap_set = '0;
        chk("ovf_sat", 32'(ifc.ovf_cnt), 32'd255);
        ifc.flush = 1'b1;
        step();
        ifc.flush = 1'b0;
        chk("ovf_flush_flag", 32'(ifc.ovf),        32'h0);
        chk("ovf_flush_cnt",  32'(ifc.ovf_cnt),    32'h0);
        chk("ovf_flush_pend", 32'(ifc.tq_pending), 32'h0);
`endif

        // Trap while disabled -> sticky error mode
        ifc.trap_en  = 1'b0;
        ifc.trap_set = 6'b000010;
        step();
        ifc.trap_set = '0;
        chk("err_mode",    32'(ifc.error_mode), 32'h1);
        chk("err_req",     32'(ifc.trap_req),   32'h0);
        chk("err_pending", 32'(ifc.tq_pending), 32'h02);
        step();
        chk("err_sticky", 32'(ifc.error_mode), 32'h1);
        ifc.flush = 1'b1;
        step();
        ifc.flush = 1'b0;
        chk("err_flush_mode", 32'(ifc.error_mode), 32'h1);
        chk("err_flush_req",  32'(ifc.trap_req),   32'h0);
        ifc.trap_en = 1'b1;
        step();
        step();
        chk("err_en_noreq",  32'(ifc.trap_req),   32'h0);
        chk("err_en_mode",   32'(ifc.error_mode), 32'h1);

        // Async reset in the middle of a request
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_errmode", 32'(ifc.error_mode), 32'h0);
        ifc.trap_set = 6'b000100;
        step();
        ifc.trap_set = '0;
        step();
        chk("pre_rst_req", 32'(ifc.trap_req), 32'h1);
        chk("pre_rst_tt",  32'(ifc.trap_tt),  32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pending", 32'(ifc.tq_pending), 32'h0);
        chk("arst_req",     32'(ifc.trap_req),   32'h0);
        chk("arst_tt",      32'(ifc.trap_tt),    32'h0);
        chk("arst_ackerr",  32'(ifc.ack_err),    32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_req",     32'(ifc.trap_req),   32'h0);
        chk("post_rst_pending", 32'(ifc.tq_pending), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_queue.md
Name: trap_queue

Overview:
- Pending-trap register and trap issue sequencer for the SPARC datapath.
- Collects one-hot trap request pulses from execution/memory stages and holds them as a pending vector for the tt priority encoder.
- Presents the highest-priority trap to the control unit through a req/ack handshake.
- Decodes the acknowledged 3-bit trap type back to one-hot and clears that pending bit.

Parameters:
- NUM_TRAPS, 6, number of trap sources; bit 0 is highest priority.
- TT_W, 3, width of the trap type code; must satisfy 2**TT_W >= NUM_TRAPS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- trap_set  input  NUM_TRAPS  one-cycle pulses, one bit per trap source.
- trap_en  input  1  PSR.ET; traps enabled when 1.
- flush  input  1  synchronous clear of all pending traps and the FSM.
- ack  input  1  control unit accepts the presented trap.
- ack_tt  input  TT_W  trap type being acknowledged.
- tq_pending  output  NUM_TRAPS  registered pending vector; feeds the tt encoder.
- trap_req  output  1  a trap is presented.
- trap_tt  output  TT_W  type of the presented trap; stable while trap_req=1.
- error_mode  output  1  sticky: a trap arrived while trap_en=0.
- ack_err  output  1  one-cycle pulse: ack with ack_tt != trap_tt.

Behaviour:
- Reset (async, rst_n=0): tq_pending=0, trap_req=0, trap_tt=0, error_mode=0, ack_err=0, state=IDLE.
- Pending update each cycle: pending_next = (pending & ~clr_mask) | trap_set.
  - clr_mask = one-hot decode of ack_tt, applied only when an ack is honored.
  - Set wins over clear on the same bit in the same cycle; the bit stays pending.
- Priority: lowest set index wins; index i maps to tt=i. This is the same mapping as the tt encoder.
- States:
  - IDLE: trap_req=0.
    - If trap_en=1 and (pending != 0), go to REQ next cycle and latch trap_tt = priority index of the current registered pending.
    - If trap_en=0 and any trap_set bit = 1, go to ERROR.
  - REQ: trap_req=1; trap_tt held constant.
    - A higher-priority trap arriving during REQ only updates tq_pending; it does not change trap_tt.
    - ack=1 with ack_tt==trap_tt: clear that bit, go to IDLE (trap_req=0 next cycle). At least one IDLE cycle separates consecutive requests.
    - ack=1 with ack_tt!=trap_tt: no clear, stay in REQ, pulse ack_err for 1 cycle.
    - ack=0: stay in REQ.
  - ERROR: error_mode=1, trap_req=0, pending continues to accumulate. Exit only by reset; flush does not exit.
- trap_en dropping while in REQ: no effect; the request stays presented until acked.
- flush (IDLE or REQ): next cycle tq_pending=0, trap_req=0, state=IDLE. trap_set in the flush cycle is discarded.
- ack in IDLE or ERROR: ignored, no ack_err.
- Latency: trap_set at cycle N → tq_pending at N+1 → trap_req at N+2 (IDLE, trap_en=1).
- ack_tt >= NUM_TRAPS: treated as a mismatch.

Optional Feature:
- Macro: TRAP_QUEUE_OVF_EN.
- Defined:
  - Adds output ovf (1 bit) and output ovf_cnt (8 bits).
  - A trap_set on a bit already pending (and not cleared the same cycle) sets ovf sticky and increments ovf_cnt, saturating at 255.
  - flush clears ovf and ovf_cnt; reset clears both to 0.
- Undefined: the ports are absent and no counter logic is built.

Test Plan:
- Reset: rst_n=0 mid-REQ with trap_tt=2 → all outputs 0 immediately, without waiting for a clock edge; state IDLE after release.
- Priority and latency: trap_en=1, trap_set=6'b010100 at N → tq_pending=6'b010100 at N+1; trap_req=1, trap_tt=2 at N+2. ack, ack_tt=2 → tq_pending=6'b010000. Next request has trap_tt=4 after one IDLE cycle.
- Stability: in REQ with trap_tt=4, pulse trap_set=6'b000001 → trap_tt remains 4 until acked; the following request has trap_tt=0.
- Mismatch and simultaneity:
  - ack with ack_tt=3 while trap_tt=4 → ack_err pulses 1 cycle, state REQ, pending unchanged.
  - ack_tt=4 together with trap_set[4]=1 → bit 4 stays pending, FSM goes to IDLE, then re-requests tt=4.
- Error and flush:
  - trap_en=0, trap_set=6'b000010 → error_mode=1 sticky, trap_req stays 0; flush does not clear error_mode.
  - Separately, flush in REQ → tq_pending=0, trap_req=0 next cycle.
- TRAP_QUEUE_OVF_EN: set bit 1 three times while it is pending → ovf=1, ovf_cnt=2. 300 repeats → ovf_cnt=255. flush → ovf=0, ovf_cnt=0.
